pin_entry_collector: RTL and testbench



---
 rtl/pin_pkg.sv | 56 +++++
 rtl/inactivity_timer.sv | 43 ++++
 rtl/pin_entry_collector.sv | 119 +++++++++++
 tb/tb_pin_entry_collector.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_pkg.sv
// ============================================================================
// Module      : pin_pkg
// Description : Shared PIN packet type, key codes and entry-FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pin_pkg;

    localparam int         PIN_DIGITS    = 4;
    localparam logic [3:0] KEY_BACKSPACE = 4'hA;
    localparam logic [3:0] KEY_ENTER     = 4'hB;
    localparam logic [3:0] DIGIT_BLANK   = 4'hF;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;

    typedef struct packed {
        logic       status;
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
    } pinPac_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } entry_state_t;

    localparam pinPac_t c_PIN_BLANK = '{
        status: 1'b0,
        digit1: DIGIT_BLANK,
        digit2: DIGIT_BLANK,
        digit3: DIGIT_BLANK,
        digit4: DIGIT_BLANK
    };

    // Slots are numbered 1..4 in key order; any other slot leaves the packet untouched.
    function automatic pinPac_t pin_set_slot(input pinPac_t pin,
                                             input logic [2:0] slot,
                                             input logic [3:0] value);
        pinPac_t w_pin;
        w_pin = pin;
        case (slot)
            3'd1:    w_pin.digit1 = value;
            3'd2:    w_pin.digit2 = value;
            3'd3:    w_pin.digit3 = value;
            3'd4:    w_pin.digit4 = value;
            default: w_pin = pin;
        endcase
        return w_pin;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inactivity_timer.sv
// ============================================================================
// Module      : inactivity_timer
// Description : Counts idle cycles; expire pulses on the idle cycle that
//               completes TIMEOUT_CYCLES-1 consecutive run cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inactivity_timer #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    // The counter holds completed idle cycles, so the terminal cycle sees TIMEOUT_CYCLES-2.
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] r_count;
    logic             w_terminal;

    assign w_terminal = (r_count == c_LAST);
    assign expire     = run && !clear && w_terminal;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (run) begin
            if (w_terminal) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pin_entry_collector.sv
// ============================================================================
// Module      : pin_entry_collector
// Description : Assembles keypad digits into a 4-digit pinPac_t with
//               backspace, entry-error and inactivity-timeout handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pin_entry_collector
    import pin_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output pinPac_t    pin_out,
    output logic [2:0] digit_count,
    output logic       entry_error,
    output logic       timeout
);

    localparam logic [2:0] c_FULL_COUNT = 3'(PIN_DIGITS);

    entry_state_t r_state;
    pinPac_t      r_pin;
    logic [2:0]   r_count;
    logic         r_error;
    logic         r_timeout;

    logic w_is_digit;
    logic w_key_known;
    logic w_in_collect;
    logic w_clear;
    logic w_run;
    logic w_expire;

    assign w_is_digit   = (key_code <= KEY_DIGIT_MAX);
    assign w_key_known  = (key_code <= KEY_ENTER);
    assign w_in_collect = (r_state == ST_COLLECT);

    // Codes 0xC-0xF neither restart nor advance the idle count.
    assign w_clear = !w_in_collect || !enable || (key_valid && w_key_known);
    assign w_run   = w_in_collect && (r_count != 3'd0) && !key_valid;

    inactivity_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_inactivity_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .run    (w_run),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        r_error   <= 1'b0;
        r_timeout <= 1'b0;
        if (rst || !enable) begin
            r_state <= ST_IDLE;
            r_pin   <= c_PIN_BLANK;
            r_count <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (key_valid) begin
                        if (w_is_digit) begin
                            if (r_count < c_FULL_COUNT) begin
                                r_pin   <= pin_set_slot(r_pin, r_count + 3'd1, key_code);
                                r_count <= r_count + 3'd1;
                            end
                        end else if (key_code == KEY_BACKSPACE) begin
                            if (r_count != 3'd0) begin
                                r_pin   <= pin_set_slot(r_pin, r_count, DIGIT_BLANK);
                                r_count <= r_count - 3'd1;
                            end
                        end else if (key_code == KEY_ENTER) begin
                            if (r_count == c_FULL_COUNT) begin
                                r_pin.status <= 1'b1;
                                r_state      <= ST_DONE;
                            end else begin
                                r_pin   <= c_PIN_BLANK;
                                r_count <= 3'd0;
                                r_error <= 1'b1;
                            end
                        end
                    end else if (w_expire) begin
                        r_pin     <= c_PIN_BLANK;
                        r_count   <= 3'd0;
                        r_timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_pin   <= c_PIN_BLANK;
                    r_count <= 3'd0;
                end
            endcase
        end
    end

    assign pin_out     = r_pin;
    assign digit_count = r_count;
    assign entry_error = r_error;
    assign timeout     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_pin_entry_collector.sv
// ============================================================================
// Module      : tb_pin_entry_collector
// Description : Self-checking bench: directed vector table, timeout sequences
//               and randomized keys against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pin_entry_collector;
    import pin_pkg::*;

    localparam int         c_T = 10;
    localparam logic [3:0] c_F = 4'hF;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       key_valid;
    logic [3:0] key_code;
    pinPac_t    pin_out;
    logic [2:0] digit_count;
    logic       entry_error;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    pin_entry_collector #(
        .TIMEOUT_CYCLES (c_T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .pin_out     (pin_out),
        .digit_count (digit_count),
        .entry_error (entry_error),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: digits as a queue in key order, plus session mode and idle run length.
    int q[$];
    int m_mode = 0;   // 0 idle, 1 collecting, 2 confirmed
    int m_idle = 0;
    bit m_err  = 1'b0;
    bit m_to   = 1'b0;

    typedef struct {
        logic        r;
        logic        e;
        logic        kv;
        logic [3:0]  code;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [21:0] pack(input logic st, input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c, input logic [3:0] d,
                                         input logic [2:0] n, input logic er, input logic to);
        return {st, a, b, c, d, n, er, to};
    endfunction

    function automatic logic [21:0] dut_word();
        return {pin_out, digit_count, entry_error, timeout};
    endfunction

    function automatic logic [21:0] model_word();
        logic [3:0] d [4];
        for (int i = 0; i < 4; i++) d[i] = (i < q.size()) ? 4'(q[i]) : c_F;
        return pack(m_mode == 2, d[0], d[1], d[2], d[3], 3'(q.size()), m_err, m_to);
    endfunction

    function automatic void model_step(input logic r, input logic e, input logic kv, input int code);
        m_err = 1'b0;
        m_to  = 1'b0;
        if (r || !e) begin
            q.delete();
            m_mode = 0;
            m_idle = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (kv) begin
                if (code <= 9) begin
                    if (q.size() < 4) q.push_back(code);
                    m_idle = 0;
                end else if (code == 10) begin
                    if (q.size() > 0) void'(q.pop_back());
                    m_idle = 0;
                end else if (code == 11) begin
                    m_idle = 0;
                    if (q.size() == 4) begin
                        m_mode = 2;
                    end else begin
                        m_err = 1'b1;
                        q.delete();
                    end
                end
            end else if (q.size() > 0) begin
                m_idle++;
                if (m_idle == c_T - 1) begin
                    m_to = 1'b1;
                    q.delete();
                    m_idle = 0;
                end
            end
        end
    endfunction

    task automatic step(input logic r, input logic e, input logic kv, input logic [3:0] code);
        rst       = r;
        enable    = e;
        key_valid = kv;
        key_code  = code;
        @(posedge clk);
        model_step(r, e, kv, int'(code));
        #1;
    endtask

    task automatic check(input string name, input logic [21:0] exp);
        tests++;
        if (dut_word() !== exp) begin
            fails++;
            $display("FAIL %s: got %h (st,d1..d4,cnt,err,to) expected %h", name, dut_word(), exp);
        end
    endtask

    task automatic tv(input logic r, input logic e, input logic kv, input logic [3:0] code,
                      input logic st, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d,
                      input logic [2:0] n, input logic er, input logic to);
        vec_t v;
        v.r    = r;
        v.e    = e;
        v.kv   = kv;
        v.code = code;
        v.exp  = pack(st, a, b, c, d, n, er, to);
        tbl.push_back(v);
    endtask

    initial begin
        int rate;
        logic r, e, kv;
        logic [3:0] code;

        // confirm 1234, held in DONE against keys, then released
        tv(1,0,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,1,1,4'h9, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,1,1,4'h1, 0,1,c_F,c_F,c_F,1,0,0);
        tv(0,1,1,4'h2, 0,1,2,c_F,c_F,2,0,0);
        tv(0,1,1,4'h3, 0,1,2,3,c_F,3,0,0);
        tv(0,1,1,4'h4, 0,1,2,3,4,4,0,0);
        tv(0,1,1,4'hB, 1,1,2,3,4,4,0,0);
        tv(0,1,1,4'h9, 1,1,2,3,4,4,0,0);
        tv(0,1,1,4'hA, 1,1,2,3,4,4,0,0);
        tv(0,1,0,4'h0, 1,1,2,3,4,4,0,0);
        tv(0,0,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,0,1,4'h5, 0,c_F,c_F,c_F,c_F,0,0,0);
        // backspace in the middle of an entry
        tv(0,1,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,1,1,4'h5, 0,5,c_F,c_F,c_F,1,0,0);
        tv(0,1,1,4'h6, 0,5,6,c_F,c_F,2,0,0);
        tv(0,1,1,4'h7, 0,5,6,7,c_F,3,0,0);
        tv(0,1,1,4'hA, 0,5,6,c_F,c_F,2,0,0);
        tv(0,1,1,4'h8, 0,5,6,8,c_F,3,0,0);
        tv(0,1,1,4'h9, 0,5,6,8,9,4,0,0);
        tv(0,1,1,4'hB, 1,5,6,8,9,4,0,0);
        tv(0,0,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);
        // short entry error, then a good entry
        tv(0,1,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,1,1,4'h1, 0,1,c_F,c_F,c_F,1,0,0);
        tv(0,1,1,4'h2, 0,1,2,c_F,c_F,2,0,0);
        tv(0,1,1,4'hB, 0,c_F,c_F,c_F,c_F,0,1,0);
        tv(0,1,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,1,1,4'h4, 0,4,c_F,c_F,c_F,1,0,0);
        tv(0,1,1,4'h3, 0,4,3,c_F,c_F,2,0,0);
        tv(0,1,1,4'h2, 0,4,3,2,c_F,3,0,0);
        tv(0,1,1,4'h1, 0,4,3,2,1,4,0,0);
        tv(0,1,1,4'hB, 1,4,3,2,1,4,0,0);
        tv(0,0,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);
        // enable drops together with a key
        tv(0,1,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,1,1,4'h1, 0,1,c_F,c_F,c_F,1,0,0);
        tv(0,1,1,4'h2, 0,1,2,c_F,c_F,2,0,0);
        tv(0,1,1,4'h3, 0,1,2,3,c_F,3,0,0);
        tv(0,0,1,4'h4, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,0,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);
        // fifth digit and ignored code, then confirm
        tv(0,1,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,1,1,4'h1, 0,1,c_F,c_F,c_F,1,0,0);
        tv(0,1,1,4'h2, 0,1,2,c_F,c_F,2,0,0);
        tv(0,1,1,4'h3, 0,1,2,3,c_F,3,0,0);
        tv(0,1,1,4'h4, 0,1,2,3,4,4,0,0);
        tv(0,1,1,4'h5, 0,1,2,3,4,4,0,0);
        tv(0,1,1,4'hC, 0,1,2,3,4,4,0,0);
        tv(0,1,1,4'hB, 1,1,2,3,4,4,0,0);
        tv(0,0,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);
        // reset mid-entry, then backspace down to and past empty
        tv(0,1,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,1,1,4'h7, 0,7,c_F,c_F,c_F,1,0,0);
        tv(0,1,1,4'h8, 0,7,8,c_F,c_F,2,0,0);
        tv(1,1,1,4'h9, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,1,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,1,1,4'h1, 0,1,c_F,c_F,c_F,1,0,0);
        tv(0,1,1,4'hA, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,1,1,4'hA, 0,c_F,c_F,c_F,c_F,0,0,0);
        tv(0,0,0,4'h0, 0,c_F,c_F,c_F,c_F,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].kv, tbl[i].code);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // timeout: key 7 followed by nine idle cycles
        step(0, 1, 0, 4'h0);
        step(0, 1, 1, 4'h7);
        check("to_key", pack(0,7,c_F,c_F,c_F,1,0,0));
        for (int j = 1; j < c_T - 1; j++) begin
            step(0, 1, 0, 4'h0);
            check($sformatf("to_wait%0d", j), pack(0,7,c_F,c_F,c_F,1,0,0));
        end
        step(0, 1, 0, 4'h0);
        check("to_pulse", pack(0,c_F,c_F,c_F,c_F,0,0,1));
        step(0, 1, 0, 4'h0);
        check("to_after", pack(0,c_F,c_F,c_F,c_F,0,0,0));

        // key in the terminal cycle wins, and restarts the idle count
        step(0, 1, 1, 4'h7);
        for (int j = 1; j < c_T - 1; j++) step(0, 1, 0, 4'h0);
        step(0, 1, 1, 4'h3);
        check("to_keywins", pack(0,7,3,c_F,c_F,2,0,0));
        for (int j = 1; j < c_T - 1; j++) begin
            step(0, 1, 0, 4'h0);
            check($sformatf("to_rewait%0d", j), pack(0,7,3,c_F,c_F,2,0,0));
        end
        step(0, 1, 0, 4'h0);
        check("to_repulse", pack(0,c_F,c_F,c_F,c_F,0,0,1));

        // randomized traffic against the reference model
        rate = 0;
        for (int n = 0; n < 4000; n++) begin
            int p;
            if (n % 40 == 0) rate = int'($urandom_range(0, 3));
            r  = ($urandom_range(0, 299) == 0);
            e  = ($urandom_range(0, 79) != 0);
            kv = (rate == 0) ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, rate) == 0);
            p  = int'($urandom_range(0, 15));
            if (p < 10)      code = 4'($urandom_range(0, 9));
            else if (p < 12) code = KEY_BACKSPACE;
            else if (p < 14) code = KEY_ENTER;
            else             code = 4'($urandom_range(12, 15));
            step(r, e, kv, code);
            check($sformatf("rand%0d", n), model_word());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
